cordic_post_scale: RTL and testbench

- Downstream consumer of the CORDIC core's st_cordic_out stream (18-bit x/y/z, valid-only, no backpressure).
- Applies the 12-rotation CORDIC gain compensation to x and y, then rounds and saturates x, y and z back to 16-bit cordic_data_in format.
- Buffers results in a small FIFO so the sink can apply valid/ready backpressure.
- Reports dropped results and saturation events.

---
 rtl/cordic_post_scale.sv | 129 ++++++++++++
 tb/tb_cordic_post_scale.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_post_scale.sv
// CORDIC post-processing: removes the 12-rotation gain from x/y, rounds and
// saturates x/y/z to 16 bits, and buffers results for a backpressured sink.
package cordic_pkg;
  typedef struct packed {
    logic               vld;
    logic signed [17:0] x;
    logic signed [17:0] y;
    logic signed [17:0] z;
  } st_cordic_out;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } cordic_data_in;
endpackage

module cordic_post_scale
  import cordic_pkg::*;
#(
  parameter int unsigned GAIN_COMP  = 19898,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SAT_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  st_cordic_out         cordic_out_i,
  output logic                 out_vld_o,
  input  logic                 out_rdy_i,
  output cordic_data_in        out_data_o,
  output logic                 ovf_o,
  input  logic                 ovf_clr_i,
  output logic [SAT_CNT_W-1:0] sat_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0]      FULL_C = CW'(FIFO_DEPTH);
  localparam logic signed [33:0] GAIN_X = 34'(GAIN_COMP[15:0]);

  // Stage 1: gain multiply (signed 18b x unsigned 16b -> signed 34b).
  logic signed [33:0] x_ext, y_ext, mul_x, mul_y;
  logic               s1_vld;
  logic signed [33:0] s1_px, s1_py;
  logic signed [17:0] s1_z;

  assign x_ext = 34'(cordic_out_i.x);
  assign y_ext = 34'(cordic_out_i.y);
  assign mul_x = x_ext * GAIN_X;
  assign mul_y = y_ext * GAIN_X;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= cordic_out_i.vld;
    end
    s1_px <= mul_x;
    s1_py <= mul_y;
    s1_z  <= cordic_out_i.z;
  end

  // Round half toward +inf at bit 15, then clamp; bit 16 of the result flags saturation.
  function automatic logic [16:0] rnd_sat(input logic signed [33:0] p);
    logic signed [19:0] q;
    q = 20'((35'(p) + 35'sd16384) >>> 15);
    if (q > 20'sd32767)       return {1'b1, 16'h7fff};
    else if (q < -20'sd32768) return {1'b1, 16'h8000};
    else                      return {1'b0, q[15:0]};
  endfunction

  logic [16:0]   rx, ry;
  logic [16:0]   rz;
  logic          sat;
  cordic_data_in wr_data;

  always_comb begin
    rx = rnd_sat(s1_px);
    ry = rnd_sat(s1_py);
    if (s1_z > 18'sd32767)       rz = {1'b1, 16'h7fff};
    else if (s1_z < -18'sd32768) rz = {1'b1, 16'h8000};
    else                         rz = {1'b0, s1_z[15:0]};
    sat       = rx[16] | ry[16] | rz[16];
    wr_data.x = rx[15:0];
    wr_data.y = ry[15:0];
    wr_data.z = rz[15:0];
  end

  // Handshake: a result transfers on any cycle where out_vld_o && out_rdy_i;
  // out_vld_o never depends on out_rdy_i and the head stays put until popped.
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  cordic_data_in mem [FIFO_DEPTH];
  logic          full, pop, push, drop;

  assign full      = (count == FULL_C);
  assign out_vld_o = (count != '0);
  assign pop       = out_vld_o && out_rdy_i;
  assign push      = s1_vld && (!full || pop);
  assign drop      = s1_vld && full && !pop;
  assign out_data_o = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ovf_o     <= 1'b0;
      sat_cnt_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new drop outranks a clear in the same cycle.
      if (drop)           ovf_o <= 1'b1;
      else if (ovf_clr_i) ovf_o <= 1'b0;
      if (push && sat && sat_cnt_o != '1) sat_cnt_o <= sat_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_cordic_post_scale.sv
// Directed bench for cordic_post_scale: arithmetic reference model with an
// expected-result queue, per-cycle output compare, and literal spot checks.
module tb_cordic_post_scale;
  import cordic_pkg::*;

  localparam int DEPTH = 4;
  localparam int GAIN  = 19898;

  logic          clk = 1'b0;
  logic          rst;
  st_cordic_out  cin;
  logic          out_vld;
  logic          out_rdy;
  cordic_data_in out_data;
  logic          ovf;
  logic          ovf_clr;
  logic [15:0]   sat_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  cordic_post_scale #(.GAIN_COMP(GAIN), .FIFO_DEPTH(DEPTH), .SAT_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cordic_out_i(cin), .out_vld_o(out_vld),
    .out_rdy_i(out_rdy), .out_data_o(out_data), .ovf_o(ovf),
    .ovf_clr_i(ovf_clr), .sat_cnt_o(sat_cnt)
  );

  // ---------------- clock/reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic longint scale(input int v);
    longint p;
    p = longint'(v) * GAIN + 16384;
    if (p >= 0) return p / 32768;
    else        return -((-p + 32767) / 32768);
  endfunction

  function automatic longint sat16(input longint v);
    if (v > 32767)       return 32767;
    else if (v < -32768) return -32768;
    else                 return v;
  endfunction

  logic [47:0] exp_q[$];
  logic        model_on = 1'b0;
  logic        fl_vld = 1'b0;
  int          fl_x, fl_y, fl_z;
  logic        m_ovf = 1'b0;
  logic [15:0] m_sat = '0;

  always @(posedge clk) begin
    if (model_on) begin
      if (rst) begin
        exp_q.delete();
        fl_vld <= 1'b0;
        m_ovf  <= 1'b0;
        m_sat  <= '0;
      end else begin
        bit pop, acc, drp, s;
        longint vx, vy, vz;
        pop = (exp_q.size() != 0) && out_rdy;
        acc = 1'b0;
        drp = 1'b0;
        s   = 1'b0;
        vx  = 0; vy = 0; vz = 0;
        if (fl_vld) begin
          vx = scale(fl_x);
          vy = scale(fl_y);
          vz = fl_z;
          s  = (sat16(vx) != vx) || (sat16(vy) != vy) || (sat16(vz) != vz);
          if (exp_q.size() < DEPTH || pop) acc = 1'b1;
          else                             drp = 1'b1;
        end
        if (pop) void'(exp_q.pop_front());
        if (acc) begin
          exp_q.push_back({16'(sat16(vx)), 16'(sat16(vy)), 16'(sat16(vz))});
          if (s && m_sat != 16'hffff) m_sat <= m_sat + 16'd1;
        end
        if (drp)          m_ovf <= 1'b1;
        else if (ovf_clr) m_ovf <= 1'b0;
        fl_vld <= cin.vld;
        fl_x   <= int'(cin.x);
        fl_y   <= int'(cin.y);
        fl_z   <= int'(cin.z);
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (model_on) begin
      n_checks++;
      if (out_vld !== (exp_q.size() != 0)) begin
        n_fail++;
        $display("FAIL out_vld: got %b want %b", out_vld, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        n_checks++;
        if (out_data !== exp_q[0]) begin
          n_fail++;
          $display("FAIL out_data: got %h want %h", out_data, exp_q[0]);
        end
      end
      n_checks++;
      if (ovf !== m_ovf) begin
        n_fail++;
        $display("FAIL ovf: got %b want %b", ovf, m_ovf);
      end
      n_checks++;
      if (sat_cnt !== m_sat) begin
        n_fail++;
        $display("FAIL sat_cnt: got %0d want %0d", sat_cnt, m_sat);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic cyc(input bit v, input int x, input int y, input int z);
    @(negedge clk);
    cin.vld = v;
    cin.x   = 18'(x);
    cin.y   = 18'(y);
    cin.z   = 18'(z);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; out_rdy = 1'b1; ovf_clr = 1'b0;
    cin = '0;
    model_on = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    chk("reset_vld", int'(out_vld), 0);
    chk("reset_ovf", int'(ovf), 0);
    chk("reset_sat", int'(sat_cnt), 0);

    // single result, latency 2
    cyc(1'b1, 10000, -10000, -5);
    idle(2);
    chk("t1_vld", int'(out_vld), 1);
    chk("t1_x", int'(out_data.x), 6072);
    chk("t1_y", int'(out_data.y), -6072);
    chk("t1_z", int'(out_data.z), -5);
    chk("t1_sat", int'(sat_cnt), 0);
    idle(1);
    chk("t1_vld_after", int'(out_vld), 0);

    // saturation
    cyc(1'b1, 131071, -131072, 40000);
    cyc(1'b1, 0, 0, -40000);
    idle(1);
    chk("t2_x", int'(out_data.x), 32767);
    chk("t2_y", int'(out_data.y), -32768);
    chk("t2_z", int'(out_data.z), 32767);
    chk("t2_sat1", int'(sat_cnt), 1);
    idle(1);
    chk("t2_z2", int'(out_data.z), -32768);
    chk("t2_sat2", int'(sat_cnt), 2);
    idle(2);

    // backpressure and overflow
    out_rdy = 1'b0;
    for (int i = 1; i <= 6; i++) cyc(1'b1, i, 0, 0);
    idle(3);
    chk("t3_ovf", int'(ovf), 1);
    chk("t3_head_x", int'(out_data.x), 1);
    out_rdy = 1'b1;
    idle(4);
    chk("t3_drained", int'(out_vld), 0);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", int'(ovf), 0);

    // full FIFO with a pop every cycle: nothing dropped
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 100 + i, -i, i);
    idle(2);
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1'b1, 200 + i, 50 * i, -i);
    idle(6);
    chk("t4_ovf", int'(ovf), 0);
    chk("t4_drained", int'(out_vld), 0);

    // clear in the same cycle as a drop: set wins
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 300 + i, 0, 0);
    cyc(1'b1, 999, 0, 0);
    idle(1);
    ovf_clr = 1'b1;
    idle(1);
    chk("t5_ovf_set_wins", int'(ovf), 1);
    idle(1);
    ovf_clr = 1'b0;
    chk("t5_ovf_cleared", int'(ovf), 0);
    out_rdy = 1'b1;
    idle(6);

    // reset with 3 entries queued and 2 in flight
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1'b1, 131071, 7, i);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("t6_vld", int'(out_vld), 0);
    chk("t6_ovf", int'(ovf), 0);
    chk("t6_sat", int'(sat_cnt), 0);
    out_rdy = 1'b1;
    idle(6);
    chk("t6_no_stale", int'(out_vld), 0);

    model_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
